pipearch_dma_write_axi: RTL and testbench
=========================================

# pipearch_dma_write_axi

AXI4 write-DMA engine: the write-side counterpart of the PipeArch DMA read path. Accepts a command (line-aligned byte address, length in cache lines), buffers lines pushed by the compute side in an internal FIFO, and issues 4 KB-safe INCR bursts on an AXI4 master write channel. It signals `done` once every write response has returned.

## Interface
Parameters:
- `C_M_AXI_GMEM_ID_WIDTH`, 1, AWID/BID width
- `C_M_AXI_GMEM_ADDR_WIDTH`, 42, byte address width
- `C_M_AXI_GMEM_DATA_WIDTH`, 512, line width (64 B)
- `LOG2_FIFO_DEPTH`, 9, write-buffer depth (512 lines)
- `MAX_OUTSTANDING`, 4, max bursts awaiting B response

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `ctrl_start` in 1: command strobe, sampled only in IDLE
- `ctrl_addr` in ADDR_WIDTH: start byte address; bits [5:0] ignored (treated as 0)
- `ctrl_length` in 32: line count
- `status_idle` out 1: state==IDLE
- `status_done` out 1: one-cycle completion pulse
- `status_error` out 1: sticky BRESP error (see Configuration)
- `tx_we` in 1: push a line
- `tx_wdata` in DATA_WIDTH: line data
- `tx_almostfull` out 1: FIFO free slots ≤ 8
- `m_axi_gmem_AW*`: VALID/READY/ADDR/ID/LEN[7:0]/SIZE[2:0]
- `m_axi_gmem_AW*` tie-offs: BURST=01, LOCK=00, CACHE=0011, PROT=000, QOS=0, REGION=0
- `m_axi_gmem_W*`: VALID/READY/DATA/STRB (all ones)/LAST
- `m_axi_gmem_B*`: VALID/READY (tied 1)/ID/RESP[1:0]

## Operation
- States: IDLE, CALC, ADDR, DATA, DRAIN, DONE.
- IDLE + `ctrl_start`:
  - latch addr (low 6 bits zeroed) and `remaining = ctrl_length`.
  - Go to CALC, or to DONE when length==0.
  - `ctrl_start` outside IDLE is ignored.
- CALC:
  - `blen = min(remaining, 64, (4096 - addr[11:0]) >> 6)`.
  - Advance to ADDR only when FIFO count ≥ blen and outstanding < MAX_OUTSTANDING; otherwise hold.
- ADDR:
  - AWVALID=1, AWADDR=addr, AWLEN=blen-1, AWSIZE=3'b110.
  - On AWREADY: outstanding++, addr += blen<<6, remaining -= blen, enter DATA.
- DATA:
  - Stream blen beats from the FIFO head; WLAST on beat blen.
  - On the WLAST handshake: go to CALC if remaining>0, else DRAIN.
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE: `status_done`=1 for one cycle, then IDLE.
- B channel, any state: each BVALID decrements outstanding. If BVALID and AWREADY hit the same cycle, outstanding is unchanged.
- FIFO:
  - Writes are accepted in any state.
  - Lines beyond `ctrl_length` stay queued for the next command.
  - A write while full is a producer protocol violation and is dropped.
- Arithmetic: `remaining` and line counters are 32-bit unsigned; outstanding is `$clog2(MAX_OUTSTANDING+1)` bits; addr is ADDR_WIDTH and wraps modulo 2^ADDR_WIDTH.
- Reset mid-operation:
  - return to IDLE, flush the FIFO, clear outstanding and `status_error`.
  - Bursts already in flight are abandoned; their B responses are absorbed without underflow (saturate at 0).

## Timing
- Reset values: AWVALID=0, WVALID=0, WLAST=0, status_done=0, status_error=0, status_idle=1, tx_almostfull=0.
- AW outputs are registered and held stable until AWREADY.
- W uses the FIFO show-ahead output: WVALID=1 in DATA while the head is valid. Because CALC guarantees enough data, WVALID never drops mid-burst. WDATA is held while WREADY=0.
- Minimum start-to-AWVALID: 2 cycles (IDLE→CALC→ADDR) when data is already buffered.
- Inter-burst gap: 1 cycle (CALC) after WLAST.
- `status_done` follows the last BVALID by 2 cycles (DRAIN→DONE, registered pulse).
- `tx_almostfull` is registered, one cycle of lag; a threshold of 8 absorbs producer pipeline slack.

## Configuration
- `PIPEARCH_DMA_WRITE_BRESP_CHECK_EN` defined:
  - BRESP ≠ 00 on any B handshake sets `status_error`.
  - `status_error` clears only on reset or the next accepted `ctrl_start`.
  - Completion is unaffected.
- Undefined: `status_error` is tied 0 and BRESP/BID are ignored.

## Structure
- Shared package `pipearch_common` holds:
  - state enum `t_dma_write_state`
  - constants `LP_AXI_BURST_LEN`=64, `LP_4K_LINES`=64, `LP_ALMOSTFULL_SLACK`=8
  - AXI tie-off constants
- One sub-module: the codebase `fifo` (`fifobram_interface`, WIDTH=DATA_WIDTH, LOG2_DEPTH=LOG2_FIFO_DEPTH). All control logic stays in this module.

## Test plan
- Prefill 16 lines, start addr 0x1000, len 16, AW/W/B always ready → one AW (ADDR 0x1000, LEN 15), 16 W beats with WLAST on 16th, done 2 cycles after B.
- addr 0x0FC0, len 3, lines prefilled → bursts LEN 0 @0x0FC0 then LEN 1 @0x1000 (4 KB split), one done.
- len 200, producer pushes slowly, BVALID delayed 50 cycles → bursts 64/64/64/8; never more than 4 outstanding; WVALID never drops mid-burst.
- len 0 → no AW/W traffic; done pulse 2 cycles after start.
- With the macro defined, BRESP=10 on the 2nd of 3 bursts → `status_error` rises and stays; done still pulses. Without the macro → `status_error` stays 0.
- Reset asserted mid-DATA (beat 5 of 32) → next cycle AWVALID=WVALID=0, idle=1, FIFO empty; a fresh len-4 command then completes normally.

Source files
------------

// File: rtl/pipearch_dma_write_axi_pkg.sv
// pipearch_common: state enum, burst/FIFO constants and AXI tie-offs shared by the write DMA
package pipearch_common;
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DRAIN, S_DONE} t_dma_write_state;
  localparam int LP_AXI_BURST_LEN = 64;
  localparam int LP_4K_LINES = 64;
  localparam int LP_ALMOSTFULL_SLACK = 8;
  localparam logic [2:0] LP_AXI_SIZE_64B = 3'b110;
  localparam logic [1:0] LP_AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] LP_AXI_LOCK = 2'b00;
  localparam logic [3:0] LP_AXI_CACHE = 4'b0011;
  localparam logic [2:0] LP_AXI_PROT = 3'b000;
  localparam logic [3:0] LP_AXI_QOS = 4'h0;
  localparam logic [3:0] LP_AXI_REGION = 4'h0;
  // lines in the next burst: bounded by what is left, the AXI burst cap and the 4 KB page end
  function automatic logic [6:0] burst_lines(input logic [31:0] remaining, input logic [5:0] line_in_page);
    logic [6:0] lim;
    lim = 7'(LP_4K_LINES) - {1'b0, line_in_page};
    lim = (lim > 7'(LP_AXI_BURST_LEN)) ? 7'(LP_AXI_BURST_LEN) : lim;
    return (remaining < {25'd0, lim}) ? remaining[6:0] : lim;
  endfunction
endpackage

// File: rtl/pipearch_dma_write_axi_if.sv
// pipearch_dma_write_axi_if: AXI4 write-only bundle (AW, W, B) between the write DMA and memory
interface pipearch_dma_write_axi_if #(
  parameter int ID_WIDTH = 1,
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512
);
  logic awvalid, awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [ID_WIDTH-1:0] awid;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst, awlock;
  logic [3:0] awcache, awqos, awregion;
  logic wvalid, wready, wlast;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic bvalid, bready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
    input awready,
    output wvalid, wdata, wstrb, wlast,
    input wready,
    input bvalid, bid, bresp,
    output bready
  );
  modport slave (
    input awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
    output awready,
    input wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input bready
  );
endinterface

// File: rtl/pipearch_dma_write_axi_fifo.sv
// pipearch_dma_write_axi_fifo: show-ahead line buffer; head is visible on dout whenever valid
module pipearch_dma_write_axi_fifo #(
  parameter int WIDTH = 512,
  parameter int LOG2_DEPTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [WIDTH-1:0]      din,
  input  logic                  re,
  output logic [WIDTH-1:0]      dout,
  output logic                  valid,
  output logic [LOG2_DEPTH:0]   count
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  // a push while full is a producer violation and is simply dropped
  assign push = we && count != (LOG2_DEPTH+1)'(DEPTH);
  assign valid = count != '0;
  assign pop = re && valid;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + LOG2_DEPTH'(push);
      rd_ptr <= rd_ptr + LOG2_DEPTH'(pop);
      count <= count + (LOG2_DEPTH+1)'(push) - (LOG2_DEPTH+1)'(pop);
    end
  end
endmodule

// File: rtl/pipearch_dma_write_axi.sv
// pipearch_dma_write_axi: buffers pushed lines and writes them as 4 KB-safe AXI4 INCR bursts.
// Define PIPEARCH_DMA_WRITE_BRESP_CHECK_EN to make status_error a sticky BRESP error flag.
module pipearch_dma_write_axi
  import pipearch_common::*;
#(
  parameter int C_M_AXI_GMEM_ID_WIDTH = 1,
  parameter int C_M_AXI_GMEM_ADDR_WIDTH = 42,
  parameter int C_M_AXI_GMEM_DATA_WIDTH = 512,
  parameter int LOG2_FIFO_DEPTH = 9,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ctrl_start,
  input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [31:0]                        ctrl_length,
  output logic                               status_idle,
  output logic                               status_done,
  output logic                               status_error,
  input  logic                               tx_we,
  input  logic [C_M_AXI_GMEM_DATA_WIDTH-1:0] tx_wdata,
  output logic                               tx_almostfull,
  pipearch_dma_write_axi_if.master           m_axi_gmem
);
  localparam int AW = C_M_AXI_GMEM_ADDR_WIDTH;
  localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  t_dma_write_state state;
  logic [AW-1:0] addr;
  logic [31:0] remaining;
  logic [6:0] blen, blen_c, beat;
  logic [OW-1:0] outstanding;
  logic [C_M_AXI_GMEM_DATA_WIDTH-1:0] fifo_dout;
  logic [LOG2_FIFO_DEPTH:0] fifo_count;
  logic fifo_valid, aw_hs, w_hs, b_hs, unused;
  pipearch_dma_write_axi_fifo #(.WIDTH(C_M_AXI_GMEM_DATA_WIDTH), .LOG2_DEPTH(LOG2_FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .we(tx_we), .din(tx_wdata), .re(w_hs),
    .dout(fifo_dout), .valid(fifo_valid), .count(fifo_count)
  );
  assign blen_c = burst_lines(remaining, addr[11:6]);
  assign aw_hs = m_axi_gmem.awvalid && m_axi_gmem.awready;
  assign w_hs = m_axi_gmem.wvalid && m_axi_gmem.wready;
  assign b_hs = m_axi_gmem.bvalid;
  assign m_axi_gmem.awvalid = state == S_ADDR;
  assign m_axi_gmem.awaddr = addr;
  assign m_axi_gmem.awid = C_M_AXI_GMEM_ID_WIDTH'(0);
  assign m_axi_gmem.awlen = {1'b0, blen - 7'd1};
  assign m_axi_gmem.awsize = LP_AXI_SIZE_64B;
  assign m_axi_gmem.awburst = LP_AXI_BURST_INCR;
  assign m_axi_gmem.awlock = LP_AXI_LOCK;
  assign m_axi_gmem.awcache = LP_AXI_CACHE;
  assign m_axi_gmem.awprot = LP_AXI_PROT;
  assign m_axi_gmem.awqos = LP_AXI_QOS;
  assign m_axi_gmem.awregion = LP_AXI_REGION;
  assign m_axi_gmem.wvalid = state == S_DATA && fifo_valid;
  assign m_axi_gmem.wdata = fifo_dout;
  assign m_axi_gmem.wstrb = '1;
  assign m_axi_gmem.wlast = state == S_DATA && beat == blen - 7'd1;
  assign m_axi_gmem.bready = 1'b1;
  assign status_idle = state == S_IDLE;
  assign status_done = state == S_DONE;
  assign unused = &{1'b0, ctrl_addr[5:0], m_axi_gmem.bid, m_axi_gmem.bresp};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      addr <= '0;
      remaining <= '0;
      blen <= 7'd1;
      beat <= '0;
      outstanding <= '0;
    end else begin
      // responses to bursts abandoned by a reset arrive with outstanding==0 and must not wrap it
      outstanding <= (aw_hs && !b_hs) ? outstanding + OW'(1) :
                     (b_hs && !aw_hs && outstanding != '0) ? outstanding - OW'(1) : outstanding;
      case (state)
        S_IDLE: if (ctrl_start) begin
          addr <= {ctrl_addr[AW-1:6], 6'd0};
          remaining <= ctrl_length;
          state <= (ctrl_length == '0) ? S_DONE : S_CALC;
        end
        S_CALC: if (32'(fifo_count) >= 32'(blen_c) && outstanding < OW'(MAX_OUTSTANDING)) begin
          blen <= blen_c;
          state <= S_ADDR;
        end
        S_ADDR: if (m_axi_gmem.awready) begin
          addr <= addr + AW'({blen, 6'd0});
          remaining <= remaining - 32'(blen);
          beat <= '0;
          state <= S_DATA;
        end
        S_DATA: if (w_hs) begin
          beat <= beat + 7'd1;
          if (m_axi_gmem.wlast) state <= (remaining != '0) ? S_CALC : S_DRAIN;
        end
        S_DRAIN: if (outstanding == '0) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    tx_almostfull <= reset ? 1'b0 : (32'(DEPTH) - 32'(fifo_count)) <= 32'(LP_ALMOSTFULL_SLACK);
`ifdef PIPEARCH_DMA_WRITE_BRESP_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) status_error <= 1'b0;
    else if (b_hs && m_axi_gmem.bresp != 2'b00) status_error <= 1'b1;
    else if (status_idle && ctrl_start) status_error <= 1'b0;
  end
`else
  assign status_error = 1'b0;
`endif
endmodule

// File: tb/tb_pipearch_dma_write_axi.sv
// tb_pipearch_dma_write_axi: directed bench with an AXI slave model and a line-data scoreboard
module tb_pipearch_dma_write_axi;
  localparam int AW = 42;
  localparam int DW = 512;
`ifdef PIPEARCH_DMA_WRITE_BRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_addr = '0;
  logic [31:0] ctrl_length = '0;
  logic status_idle, status_done, status_error, tx_almostfull;
  logic tx_we = 1'b0;
  logic [DW-1:0] tx_wdata = '0;
  pipearch_dma_write_axi_if #(.ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi_gmem ();
  pipearch_dma_write_axi dut (
    .clk(clk), .reset(reset), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr), .ctrl_length(ctrl_length),
    .status_idle(status_idle), .status_done(status_done), .status_error(status_error),
    .tx_we(tx_we), .tx_wdata(tx_wdata), .tx_almostfull(tx_almostfull), .m_axi_gmem(m_axi_gmem)
  );
  always #5 clk = ~clk;

  int cyc, n_cmp, n_bad, seq, start_cyc, done_base;
  int w_beats, cur_beats, data_err, drop_err, out_cnt, max_out, done_cnt, done_cyc;
  int b_sent, last_b_cyc;
  int bad_b = -1;
  int bdelay = 1;
  bit stray_b, wr_rand, in_burst;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] aw_addr_q[$];
  int aw_len_q[$], aw_cyc_q[$], beats_q[$], b_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // slave: ready generation and one B per completed burst, bdelay cycles after WLAST
  always @(posedge clk) begin
    #1;
    m_axi_gmem.wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_gmem.bvalid = 1'b0;
    m_axi_gmem.bresp = 2'b00;
    if (stray_b) begin
      m_axi_gmem.bvalid = 1'b1;
      stray_b = 1'b0;
    end else if (b_q.size() != 0 && cyc >= b_q[0] + bdelay) begin
      void'(b_q.pop_front());
      m_axi_gmem.bvalid = 1'b1;
      m_axi_gmem.bresp = (b_sent == bad_b) ? 2'b10 : 2'b00;
      b_sent++;
      last_b_cyc = cyc;
    end
  end

  // monitor: values seen here are the ones the next rising edge transfers
  always @(negedge clk) begin
    if (reset) begin
      cur_beats = 0;
      out_cnt = 0;
      in_burst = 1'b0;
    end else begin
      if (m_axi_gmem.awvalid && m_axi_gmem.awready) begin
        aw_addr_q.push_back(m_axi_gmem.awaddr);
        aw_len_q.push_back(int'(m_axi_gmem.awlen));
        aw_cyc_q.push_back(cyc);
        out_cnt++;
        if (out_cnt > max_out) max_out = out_cnt;
      end
      if (in_burst && !m_axi_gmem.wvalid) drop_err++;
      if (m_axi_gmem.wvalid && m_axi_gmem.wready) begin
        w_beats++;
        cur_beats++;
        in_burst = 1'b1;
        if (exp_q.size() == 0) data_err++;
        else if (exp_q.pop_front() !== m_axi_gmem.wdata) data_err++;
        if (m_axi_gmem.wlast) begin
          beats_q.push_back(cur_beats);
          cur_beats = 0;
          in_burst = 1'b0;
          b_q.push_back(cyc);
        end
      end
      if (m_axi_gmem.bvalid) out_cnt--;
      if (status_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tx_we = 1'b1;
      tx_wdata = {16{seq}};
      exp_q.push_back(tx_wdata);
      seq++;
    end
    @(posedge clk); #1;
    tx_we = 1'b0;
  endtask

  task automatic push_slow(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tx_we = 1'b1;
      tx_wdata = {16{seq}};
      exp_q.push_back(tx_wdata);
      seq++;
      @(posedge clk); #1;
      tx_we = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input int len);
    @(posedge clk); #1;
    done_base = done_cnt;
    ctrl_start = 1'b1;
    ctrl_addr = a;
    ctrl_length = len;
    start_cyc = cyc;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (done_cnt == done_base && n < bound) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
    chk({tag, "_idle"}, status_idle, 1);
  endtask

  initial begin
    int ab, bb, wb, n;
    m_axi_gmem.awready = 1'b1;
    m_axi_gmem.bid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", m_axi_gmem.awvalid, 0);
    chk("rst_wvalid", m_axi_gmem.wvalid, 0);
    chk("rst_wlast", m_axi_gmem.wlast, 0);
    chk("rst_done", status_done, 0);
    chk("rst_error", status_error, 0);
    chk("rst_idle", status_idle, 1);
    chk("rst_almostfull", tx_almostfull, 0);
    reset = 1'b0;

    // single 16-line burst; a start strobe while busy must be ignored
    push(16);
    ab = aw_addr_q.size(); bb = beats_q.size();
    start_cmd(42'h1000, 16);
    repeat (3) @(posedge clk);
    #1;
    ctrl_start = 1'b1; ctrl_addr = 42'h5000; ctrl_length = 8;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    wait_done("t1", 300);
    chk("t1_aw_count", aw_addr_q.size() - ab, 1);
    chk("t1_awaddr", aw_addr_q[ab], 42'h1000);
    chk("t1_awlen", aw_len_q[ab], 15);
    chk("t1_start_to_aw", aw_cyc_q[ab] - start_cyc, 2);
    chk("t1_beats", beats_q[bb], 16);
    chk("t1_b_to_done", done_cyc - last_b_cyc, 2);

    // 4 KB split: one line before the page end, two after
    push(3);
    ab = aw_addr_q.size(); bb = beats_q.size();
    start_cmd(42'h0FC0, 3);
    wait_done("t2", 300);
    chk("t2_aw_count", aw_addr_q.size() - ab, 2);
    chk("t2_awaddr0", aw_addr_q[ab], 42'h0FC0);
    chk("t2_awlen0", aw_len_q[ab], 0);
    chk("t2_awaddr1", aw_addr_q[ab+1], 42'h1000);
    chk("t2_awlen1", aw_len_q[ab+1], 1);
    chk("t2_beats1", beats_q[bb+1], 2);

    // slow producer, late responses, stalling W channel
    bdelay = 50; wr_rand = 1'b1; max_out = 0;
    ab = aw_addr_q.size(); bb = beats_q.size();
    fork
      push_slow(200);
      begin
        start_cmd(42'h0, 200);
        wait_done("t3", 3000);
      end
    join
    wr_rand = 1'b0;
    chk("t3_aw_count", aw_addr_q.size() - ab, 4);
    chk("t3_awlen0", aw_len_q[ab], 63);
    chk("t3_awlen2", aw_len_q[ab+2], 63);
    chk("t3_awlen3", aw_len_q[ab+3], 7);
    chk("t3_awaddr3", aw_addr_q[ab+3], 42'h3000);
    chk("t3_beats3", beats_q[bb+3], 8);
    chk("t3_max_out_le4", max_out <= 4, 1);
    chk("t3_no_drop", drop_err, 0);

    // outstanding limit: five full bursts, responses very late
    bdelay = 400; max_out = 0;
    push(320);
    ab = aw_addr_q.size();
    start_cmd(42'h10000, 320);
    wait_done("t4", 3000);
    chk("t4_aw_count", aw_addr_q.size() - ab, 5);
    chk("t4_awaddr4", aw_addr_q[ab+4], 42'h14000);
    chk("t4_max_out", max_out, 4);

    // zero-length command
    bdelay = 1;
    ab = aw_addr_q.size(); wb = w_beats;
    start_cmd(42'h2000, 0);
    wait_done("t5", 20);
    chk("t5_no_aw", aw_addr_q.size() - ab, 0);
    chk("t5_no_w", w_beats - wb, 0);
    chk("t5_lat_le2", (done_cyc - start_cyc) <= 2, 1);

    // error response on the middle burst of three
    bad_b = b_sent + 1;
    push(66);
    ab = aw_addr_q.size();
    start_cmd(42'h0FC0, 66);
    wait_done("t6", 400);
    chk("t6_aw_count", aw_addr_q.size() - ab, 3);
    chk("t6_error_sticky", status_error, EXP_ERR);
    bad_b = -1;
    start_cmd(42'h0, 0);
    wait_done("t6b", 20);
    chk("t6_error_cleared", status_error, 0);

    // reset after five beats of a 32-line burst, then a stray response
    push(32);
    start_cmd(42'h0, 32);
    wb = w_beats; n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (w_beats < wb + 5 && n < 300);
    chk("t7_reached_beat5", w_beats >= wb + 5, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    b_q.delete();
    chk("t7_awvalid", m_axi_gmem.awvalid, 0);
    chk("t7_wvalid", m_axi_gmem.wvalid, 0);
    chk("t7_idle", status_idle, 1);
    stray_b = 1'b1;
    repeat (3) @(posedge clk);
    ab = aw_addr_q.size();
    push(4);
    start_cmd(42'h3000, 4);
    wait_done("t7", 200);
    chk("t7_aw_count", aw_addr_q.size() - ab, 1);
    chk("t7_awlen", aw_len_q[ab], 3);

    // almost-full threshold, then drain everything
    push(503);
    @(posedge clk); #1;
    chk("t8_af_503", tx_almostfull, 0);
    push(1);
    @(posedge clk); #1;
    chk("t8_af_504", tx_almostfull, 1);
    bdelay = 5;
    ab = aw_addr_q.size();
    start_cmd(42'h0, 504);
    wait_done("t8", 3000);
    chk("t8_aw_count", aw_addr_q.size() - ab, 8);
    chk("t8_awlen7", aw_len_q[ab+7], 55);
    chk("t8_af_after", tx_almostfull, 0);

    chk("all_data_errors", data_err, 0);
    chk("all_lines_consumed", exp_q.size(), 0);
    chk("all_no_drop", drop_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
